npc_unit: RTL and testbench

Parametrised program-counter and next-PC generator for the MIPS core's fetch stage. It holds the architectural PC register and computes the sequential, branch, jump and jump-register targets. It optionally implements a one-instruction branch delay slot by buffering a pending target. It sits between the decode/control logic and the instruction memory address port.

---
 rtl/npc_pkg.sv | 31 +++
 rtl/npc_if.sv | 31 +++
 rtl/npc_target.sv | 66 ++++++
 rtl/npc_unit.sv | 100 ++++++++++
 tb/tb_npc_unit.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/npc_pkg.sv
// Shared types and constants for the fetch-stage next-PC generator.
// Holds the FSM state enum, instruction geometry and the redirect priority encoding.
package npc_pkg;

    localparam int INSTR_BYTES    = 4;
    localparam int JMP_REGION_LSB = 28;

    typedef enum logic {
        SEQ  = 1'b0,
        SLOT = 1'b1
    } npc_state_t;

    // Redirect sources, listed from lowest to highest priority.
    typedef enum logic [2:0] {
        RD_NONE  = 3'd0,
        RD_BR    = 3'd1,
        RD_JMP   = 3'd2,
        RD_JR    = 3'd3,
        RD_FLUSH = 3'd4
    } redirect_t;

    function automatic redirect_t redirect_sel(input logic flush, input logic jr,
                                               input logic jmp, input logic br_taken);
        if (flush)         return RD_FLUSH;
        else if (jr)       return RD_JR;
        else if (jmp)      return RD_JMP;
        else if (br_taken) return RD_BR;
        else               return RD_NONE;
    endfunction

endpackage

// File: rtl/npc_if.sv
// Decode/control to fetch-PC interface: redirect requests in, fetch address and status out.
// master = decode/control side, slave = npc_unit.
interface npc_if #(
    parameter int ADDR_W = 32
);
    logic              stall;
    logic              flush;
    logic [ADDR_W-1:0] flush_addr;
    logic              br_taken;
    logic [15:0]       br_off;
    logic              jmp;
    logic [25:0]       jmp_idx;
    logic              jr;
    logic [ADDR_W-1:0] jr_addr;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic              in_slot;
    logic              slot_viol;
    logic              misalign;

    modport master (
        output stall, flush, flush_addr, br_taken, br_off, jmp, jmp_idx, jr, jr_addr,
        input  pc, pc_plus4, in_slot, slot_viol, misalign
    );

    modport slave (
        input  stall, flush, flush_addr, br_taken, br_off, jmp, jmp_idx, jr, jr_addr,
        output pc, pc_plus4, in_slot, slot_viol, misalign
    );

endinterface

// File: rtl/npc_target.sv
// Combinational target arithmetic for the next-PC generator: sequential, branch,
// jump, jump-register and flush targets, priority select and misalignment detect.
module npc_target
    import npc_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_addr,
    input  logic              br_taken,
    input  logic [15:0]       br_off,
    input  logic              jmp,
    input  logic [25:0]       jmp_idx,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_addr,
    output logic [ADDR_W-1:0] pc_plus4,
    output redirect_t         sel,
    output logic [ADDR_W-1:0] target,
    output logic              bad_align
);

    logic [ADDR_W-1:0] br_ext;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] jmp_tgt;
    logic [ADDR_W-1:0] jr_tgt;
    logic [ADDR_W-1:0] flush_tgt;

    assign pc_plus4 = pc + ADDR_W'(INSTR_BYTES);

    // Word offset sign-extended and scaled to bytes.
    assign br_ext = {{(ADDR_W-18){br_off[15]}}, br_off, 2'b00};
    assign br_tgt = pc_plus4 + br_ext;

    // Region bits come from the delay-slot address (pc+4), not from pc.
    if (ADDR_W > JMP_REGION_LSB) begin : g_jmp_region
        assign jmp_tgt = {pc_plus4[ADDR_W-1:JMP_REGION_LSB], jmp_idx, 2'b00};
    end else begin : g_jmp_flat
        assign jmp_tgt = {jmp_idx, 2'b00};
    end

    assign jr_tgt    = {jr_addr[ADDR_W-1:2], 2'b00};
    assign flush_tgt = {flush_addr[ADDR_W-1:2], 2'b00};

    assign sel = redirect_sel(flush, jr, jmp, br_taken);

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        target    = pc_plus4;
        bad_align = 1'b0;
        case (sel)
            RD_FLUSH: begin
                target    = flush_tgt;
                bad_align = (flush_addr[1:0] != 2'b00);
            end
            RD_JR: begin
                target    = jr_tgt;
                bad_align = (jr_addr[1:0] != 2'b00);
            end
            RD_JMP:  target = jmp_tgt;
            RD_BR:   target = br_tgt;
            default: target = pc_plus4;
        endcase
    end

endmodule

// File: rtl/npc_unit.sv
// Architectural PC register and next-PC FSM for the fetch stage, with an optional
// one-instruction branch delay slot buffering the pending redirect target.
module npc_unit
    import npc_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter bit                DELAY_SLOT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    npc_if.slave bus
);

    npc_state_t        state;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] tgt_q;
    logic              slot_viol_q;
    logic              misalign_q;

    logic [ADDR_W-1:0] pc_plus4;
    redirect_t         sel;
    logic [ADDR_W-1:0] target;
    logic              bad_align;

    npc_target #(
        .ADDR_W (ADDR_W)
    ) u_target (
        .pc         (pc_q),
        .flush      (bus.flush),
        .flush_addr (bus.flush_addr),
        .br_taken   (bus.br_taken),
        .br_off     (bus.br_off),
        .jmp        (bus.jmp),
        .jmp_idx    (bus.jmp_idx),
        .jr         (bus.jr),
        .jr_addr    (bus.jr_addr),
        .pc_plus4   (pc_plus4),
        .sel        (sel),
        .target     (target),
        .bad_align  (bad_align)
    );

    // NOTE: all state here uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: reset clears everything, including the pending target, so a reset
            // mid-slot can never leak a stale redirect into the first fetch.
            pc_q        <= RESET_PC;
            state       <= SEQ;
            tgt_q       <= '0;
            slot_viol_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else if (bus.flush) begin
            pc_q        <= target;
            state       <= SEQ;
            tgt_q       <= '0;
            slot_viol_q <= 1'b0;
            misalign_q  <= bad_align;
        end else if (bus.stall) begin
            slot_viol_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            case (state)
                SEQ: begin
                    slot_viol_q <= 1'b0;
                    misalign_q  <= (sel != RD_NONE) && bad_align;
                    if (sel != RD_NONE && DELAY_SLOT) begin
                        tgt_q <= target;
                        pc_q  <= pc_plus4;
                        state <= SLOT;
                    end else begin
                        pc_q  <= target;
                    end
                end
                SLOT: begin
                    // Redirects in the slot are dropped; the buffered target wins.
                    pc_q        <= tgt_q;
                    state       <= SEQ;
                    slot_viol_q <= bus.jr || bus.jmp || bus.br_taken;
                    misalign_q  <= 1'b0;
                end
                default: begin
                    pc_q        <= RESET_PC;
                    state       <= SEQ;
                    slot_viol_q <= 1'b0;
                    misalign_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pc_plus4  = pc_plus4;
    assign bus.in_slot   = (state == SLOT);
    assign bus.slot_viol = slot_viol_q;
    assign bus.misalign  = misalign_q;

endmodule

// File: tb/tb_npc_unit.sv
// Scoreboard bench for npc_unit: one delay-slot and one immediate-redirect instance
// driven with the same directed and random stimulus, checked against a behavioural model.
module tb_npc_unit;

    localparam logic [31:0] RPC1 = 32'h0000_0000;
    localparam logic [31:0] RPC0 = 32'h0000_0040;

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        flush;
        logic [31:0] flush_addr;
        logic        br;
        logic [15:0] br_off;
        logic        jmp;
        logic [25:0] jmp_idx;
        logic        jr;
        logic [31:0] jr_addr;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        slot;
        logic [31:0] tgt;
        logic        sv;
        logic        ma;
    } model_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    model_t m1, m0;
    model_t q1[$];
    model_t q0[$];

    always #5 clk = ~clk;

    npc_if #(.ADDR_W(32)) bus1();
    npc_if #(.ADDR_W(32)) bus0();

    npc_unit #(.ADDR_W(32), .RESET_PC(RPC1), .DELAY_SLOT(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    npc_unit #(.ADDR_W(32), .RESET_PC(RPC0), .DELAY_SLOT(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural next state, written directly from the redirect rules.
    function automatic model_t model_next(input model_t m, input stim_t s,
                                          input bit ds, input logic [31:0] rpc);
        model_t      n;
        logic [31:0] p4;
        logic [31:0] t;
        bit          redir;
        int          off;
        n     = m;
        p4    = m.pc + 32'd4;
        n.sv  = 1'b0;
        n.ma  = 1'b0;
        redir = 1'b0;
        t     = p4;
        if (s.rst) begin
            n.pc = rpc; n.slot = 1'b0; n.tgt = '0;
        end else if (s.flush) begin
            n.pc = s.flush_addr & 32'hFFFF_FFFC;
            n.slot = 1'b0; n.tgt = '0;
            n.ma = (s.flush_addr % 4) != 0;
        end else if (s.stall) begin
            // hold everything
        end else if (m.slot) begin
            n.pc = m.tgt; n.slot = 1'b0;
            n.sv = s.jr || s.jmp || s.br;
        end else begin
            if (s.jr) begin
                redir = 1'b1; t = s.jr_addr & 32'hFFFF_FFFC;
                n.ma = (s.jr_addr % 4) != 0;
            end else if (s.jmp) begin
                redir = 1'b1; t = (p4 & 32'hF000_0000) | (32'(s.jmp_idx) * 4);
            end else if (s.br) begin
                off = int'($signed(s.br_off));
                redir = 1'b1; t = p4 + 32'(off * 4);
            end
            if (redir && ds) begin
                n.tgt = t; n.pc = p4; n.slot = 1'b1;
            end else begin
                n.pc = t;
            end
        end
        return n;
    endfunction

    task automatic step(input stim_t s);
        @(negedge clk);
        #1;
        rst             = s.rst;
        bus1.stall      = s.stall;      bus0.stall      = s.stall;
        bus1.flush      = s.flush;      bus0.flush      = s.flush;
        bus1.flush_addr = s.flush_addr; bus0.flush_addr = s.flush_addr;
        bus1.br_taken   = s.br;         bus0.br_taken   = s.br;
        bus1.br_off     = s.br_off;     bus0.br_off     = s.br_off;
        bus1.jmp        = s.jmp;        bus0.jmp        = s.jmp;
        bus1.jmp_idx    = s.jmp_idx;    bus0.jmp_idx    = s.jmp_idx;
        bus1.jr         = s.jr;         bus0.jr         = s.jr;
        bus1.jr_addr    = s.jr_addr;    bus0.jr_addr    = s.jr_addr;
        m1 = model_next(m1, s, 1'b1, RPC1);
        m0 = model_next(m0, s, 1'b0, RPC0);
        q1.push_back(m1);
        q0.push_back(m0);
    endtask

    task automatic flush_to(input logic [31:0] a);
        stim_t s;
        s = '0; s.flush = 1'b1; s.flush_addr = a;
        step(s);
    endtask

    task automatic idle(input int n);
        stim_t s;
        s = '0;
        repeat (n) step(s);
    endtask

    // Monitor: one expected entry per DUT per cycle, compared mid-cycle.
    always @(negedge clk) begin
        model_t e;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("ds1.pc",        bus1.pc,                 e.pc);
            check("ds1.pc_plus4",  bus1.pc_plus4,           e.pc + 32'd4);
            check("ds1.in_slot",   32'(bus1.in_slot),       32'(e.slot));
            check("ds1.slot_viol", 32'(bus1.slot_viol),     32'(e.sv));
            check("ds1.misalign",  32'(bus1.misalign),      32'(e.ma));
        end
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check("ds0.pc",        bus0.pc,                 e.pc);
            check("ds0.pc_plus4",  bus0.pc_plus4,           e.pc + 32'd4);
            check("ds0.in_slot",   32'(bus0.in_slot),       32'(e.slot));
            check("ds0.slot_viol", 32'(bus0.slot_viol),     32'(e.sv));
            check("ds0.misalign",  32'(bus0.misalign),      32'(e.ma));
        end
    end

    initial begin
        stim_t s;
        m1 = '0;
        m0 = '0;

        // Reset, then free-run: 0x0, 0x4, 0x8, 0xC on the delay-slot instance.
        s = '0; s.rst = 1'b1;
        step(s); step(s);
        idle(4);

        // Backward branch from 0x10 with three stall cycles in the slot; br_taken held
        // through the stall must be ignored, then pulse slot_viol on the release edge.
        flush_to(32'h0000_0010);
        s = '0; s.br = 1'b1; s.br_off = 16'hFFFC;
        step(s);
        s.stall = 1'b1;
        repeat (3) step(s);
        s.stall = 1'b0;
        step(s);
        idle(2);

        // Jump with region bits taken from pc+4.
        flush_to(32'h1000_0020);
        s = '0; s.jmp = 1'b1; s.jmp_idx = 26'h000_0040;
        step(s);
        idle(2);

        // Misaligned register jump.
        s = '0; s.jr = 1'b1; s.jr_addr = 32'h0000_0203;
        step(s);
        idle(2);

        // Stalled flush while a branch target is pending.
        flush_to(32'h0000_0010);
        s = '0; s.br = 1'b1; s.br_off = 16'hFFFC;
        step(s);
        s = '0; s.stall = 1'b1; s.flush = 1'b1; s.flush_addr = 32'h8000_0180;
        step(s);
        idle(3);

        // Reset mid-slot drops the pending target.
        flush_to(32'h0000_0010);
        s = '0; s.br = 1'b1; s.br_off = 16'h0010;
        step(s);
        s = '0; s.rst = 1'b1;
        step(s);
        idle(2);

        // Misaligned flush, then sequential wrap past the top of the address space.
        flush_to(32'hFFFF_FFFA);
        idle(3);

        // Priority: all redirects at once.
        s = '0; s.jr = 1'b1; s.jr_addr = 32'h0000_4000; s.jmp = 1'b1; s.jmp_idx = 26'h3;
        s.br = 1'b1; s.br_off = 16'h0008;
        step(s);
        idle(2);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            s = '0;
            s.rst        = ($urandom_range(0, 299) == 0);
            s.stall      = ($urandom_range(0, 3) == 0);
            s.flush      = ($urandom_range(0, 15) == 0);
            s.flush_addr = $urandom();
            s.br         = ($urandom_range(0, 3) == 0);
            s.br_off     = 16'($urandom());
            s.jmp        = ($urandom_range(0, 7) == 0);
            s.jmp_idx    = 26'($urandom());
            s.jr         = ($urandom_range(0, 7) == 0);
            s.jr_addr    = $urandom();
            step(s);
        end

        s = '0;
        step(s);
        @(negedge clk);
        #2;
        check("q1_drained", 32'(q1.size()), 32'd0);
        check("q0_drained", 32'(q0.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
